// File: rtl/div_fu_pkg.sv
// Shared types and constants for the divide functional-unit controller.
// Also used by the operand conditioning block.
package div_fu_pkg;

  localparam logic [63:0] XLEN_MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] W_MIN    = 64'hFFFF_FFFF_8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    BCAST,
    DRAIN
  } div_fu_state_e;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/div_operand_cond.sv
// Word-form operand extension and divide-by-zero / overflow bypass.
// Combinational; shared with the remainder controller.
module div_operand_cond
  import div_fu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            signed_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] dividend_o,
  output logic [XLEN-1:0] divisor_o,
  output logic            bypass_o,
  output logic [XLEN-1:0] bypass_data_o
);

  logic            div0;
  logic            ovf;
  logic [XLEN-1:0] min_val;

  always_comb begin
    dividend_o = rs1_i;
    divisor_o  = rs2_i;
    if (word_i) begin
      if (signed_i) begin
        dividend_o = sext32(rs1_i[31:0]);
        divisor_o  = sext32(rs2_i[31:0]);
      end else begin
        dividend_o = {32'b0, rs1_i[31:0]};
        divisor_o  = {32'b0, rs2_i[31:0]};
      end
    end
  end

  assign min_val = word_i ? W_MIN : XLEN_MIN;
  assign div0    = (divisor_o == '0);
  assign ovf     = signed_i
                 & (dividend_o == min_val)
                 & (divisor_o == '1);

  assign bypass_o      = div0 | ovf;
  // Overflow returns the dividend itself
  assign bypass_data_o = div0 ? '1 : dividend_o;

endmodule

// File: rtl/div_fu_ctrl.sv
// Divide functional-unit controller: issue, divider handshake,
// zero/overflow bypass, CDB broadcast and flush draining.
module div_fu_ctrl
  import div_fu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic             issue_signed_i,
  input  logic             issue_word_i,
  input  logic [TAG_W-1:0] issue_tag_i,
  input  logic [XLEN-1:0]  issue_rs1_i,
  input  logic [XLEN-1:0]  issue_rs2_i,
  output logic             div_valid_o,
  input  logic             div_ready_i,
  output logic             div_signed_o,
  output logic [XLEN-1:0]  div_dividend_o,
  output logic [XLEN-1:0]  div_divisor_o,
  input  logic             div_valid_i,
  input  logic [XLEN-1:0]  div_quotient_i,
  output logic             div_yumi_o,
  output logic             cdb_req_o,
  input  logic             cdb_grant_i,
  output logic [TAG_W-1:0] cdb_tag_o,
  output logic [XLEN-1:0]  cdb_data_o,
  input  logic             flush_i
);

  div_fu_state_e    state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             sgn_q, sgn_d;
  logic             word_q, word_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  res_q, res_d;

  logic [XLEN-1:0]  c_dvd;
  logic [XLEN-1:0]  c_dvs;
  logic             c_byp;
  logic [XLEN-1:0]  c_res;

  div_operand_cond #(.XLEN(XLEN)) u_cond (
    .signed_i      (issue_signed_i),
    .word_i        (issue_word_i),
    .rs1_i         (issue_rs1_i),
    .rs2_i         (issue_rs2_i),
    .dividend_o    (c_dvd),
    .divisor_o     (c_dvs),
    .bypass_o      (c_byp),
    .bypass_data_o (c_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tag_q   <= '0;
      sgn_q   <= 1'b0;
      word_q  <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      sgn_q   <= sgn_d;
      word_q  <= word_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    sgn_d         = sgn_q;
    word_d        = word_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    res_d         = res_q;
    issue_ready_o = 1'b0;
    div_valid_o   = 1'b0;
    div_yumi_o    = 1'b0;
    cdb_req_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        issue_ready_o = 1'b1;
        if (issue_valid_i && !flush_i) begin
          tag_d  = issue_tag_i;
          sgn_d  = issue_signed_i;
          word_d = issue_word_i;
          dvd_d  = c_dvd;
          dvs_d  = c_dvs;
          if (c_byp) begin
            res_d   = c_res;
            state_d = BCAST;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        div_valid_o = 1'b1;
        if (flush_i) begin
          state_d = div_ready_i ? DRAIN : IDLE;
        end else if (div_ready_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (div_valid_i) begin
          div_yumi_o = 1'b1;
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            // W forms sign-extend the low word, unsigned included
            res_d   = word_q ? sext32(div_quotient_i[31:0])
                             : div_quotient_i;
            state_d = BCAST;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      BCAST: begin
        cdb_req_o = ~flush_i;
        if (flush_i || cdb_grant_i) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (div_valid_i) begin
          div_yumi_o = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign div_signed_o   = sgn_q;
  assign div_dividend_o = dvd_q;
  assign div_divisor_o  = dvs_q;
  assign cdb_tag_o      = tag_q;
  assign cdb_data_o     = res_q;

endmodule

// File: doc/div_fu_ctrl.md
# div_fu_ctrl

Functional-unit controller for the integer divide path of the out-of-order core. It takes DIV/DIVU/DIVW/DIVUW micro-ops from the divide reservation station and drives the iterative divider's valid/ready request and valid/yumi result handshake. It conditions operands for the word forms and resolves the RISC-V divide-by-zero and signed-overflow cases locally, without starting the divider. Each result is broadcast on the common data bus (CDB) under its ROB tag, and in-flight work is discarded on pipeline flush.

## Interface
- `XLEN`, 64: operand and result width.
- `TAG_W`, 6: ROB tag width.

- `clk`, in, 1: clock. Single clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `issue_valid_i`, in, 1: micro-op presented.
- `issue_ready_o`, out, 1: controller can accept a micro-op.
- `issue_signed_i`, in, 1: 1 selects DIV/DIVW; 0 selects DIVU/DIVUW.
- `issue_word_i`, in, 1: 1 selects a W-form operation.
- `issue_tag_i`, in, TAG_W: ROB tag.
- `issue_rs1_i`, `issue_rs2_i`, in, XLEN: dividend and divisor.
- `div_valid_o`, out, 1: request to the divider.
- `div_ready_i`, in, 1: divider idle.
- `div_signed_o`, out, 1: signed-divide control to the divider.
- `div_dividend_o`, `div_divisor_o`, out, XLEN: conditioned operands.
- `div_valid_i`, in, 1: divider result valid.
- `div_quotient_i`, in, XLEN: divider result.
- `div_yumi_o`, out, 1: result consumed.
- `cdb_req_o`, out, 1: request for the CDB.
- `cdb_grant_i`, in, 1: CDB granted this cycle.
- `cdb_tag_o`, out, TAG_W: tag being broadcast.
- `cdb_data_o`, out, XLEN: data being broadcast.
- `flush_i`, in, 1: kill all speculative work.

## Operation
**States**
- IDLE: accepting a new micro-op.
- LAUNCH: driving the divider request.
- WAIT: divider busy.
- BCAST: result held and requesting the CDB.
- DRAIN: flushed, waiting to discard the divider result.

**Accept and operand conditioning**
- A micro-op is accepted when `issue_valid_i & issue_ready_o & ~flush_i`.
- On accept, the tag, signed flag and word flag are registered, along with the conditioned operands:
  - W forms: low 32 bits of each operand, sign-extended when signed, zero-extended otherwise.
  - Other forms: operands unmodified.

**Special cases (bypass)** — these skip the divider entirely:
- Divisor == 0: result is all ones.
- Signed and dividend == minimum and divisor == all ones (minimum is `64'h8000…0`, or the sign-extended `0x80000000` for W forms): result is the dividend.
- On a special case the result register is loaded in the accept cycle and the next state is BCAST.
- Otherwise the next state is LAUNCH.

**LAUNCH**
- `div_valid_o` = 1, with operands and `div_signed_o` held stable.
- The request completes on `div_valid_o & div_ready_i`; the next state is WAIT.

**WAIT**
- On `div_valid_i`: `div_yumi_o` = 1 combinationally in the same cycle, and the result register captures the quotient.
  - W forms: result is the sign-extension of quotient[31:0], for both signed and unsigned.
  - Next state is BCAST.

**BCAST**
- `cdb_req_o` = `~flush_i`; `cdb_tag_o` and `cdb_data_o` come from registers.
- On `cdb_grant_i & ~flush_i` the result is delivered and the next state is IDLE.

**Flush** (flush wins over every simultaneous event)
- IDLE: the same-cycle issue is dropped.
- LAUNCH with the divider accepting in the same cycle: next state is DRAIN.
- LAUNCH without the divider accepting: next state is IDLE.
- WAIT without `div_valid_i`: next state is DRAIN.
- WAIT with `div_valid_i`: yumi is asserted, the result is discarded, and the next state is IDLE.
- BCAST: the result is discarded and the next state is IDLE. A grant in the flush cycle is ignored.
- DRAIN: `flush_i` has no further effect.

**DRAIN**
- `issue_ready_o` = 0.
- On `div_valid_i`: `div_yumi_o` = 1 and next state is IDLE. No CDB request is made.

## Timing
- Reset state is IDLE. Reset values:
  - `issue_ready_o` = 1.
  - `div_valid_o`, `div_yumi_o`, `cdb_req_o` = 0.
  - Tag, data and operand registers = 0.
- Reset mid-operation returns to IDLE. The divider shares `reset`, so no drain is needed.
- `issue_ready_o` = (state == IDLE). At most one micro-op is in flight.
- Bypass latency: accept at cycle N, `cdb_req_o` at N+1.
- Divider latency: accept at N, `div_valid_o` at N+1, then divider latency D, then `cdb_req_o` one cycle after `div_valid_i`.
- `cdb_tag_o` and `cdb_data_o` are stable while `cdb_req_o` is high. Back-to-back issue is possible in the cycle after a grant.
- All outputs are registered-state decodes, except:
  - `div_yumi_o`, which is combinational from `div_valid_i`;
  - `cdb_req_o`, which is gated by `flush_i`.

## Structure
- `div_fu_pkg` holds:
  - the state enum `div_fu_state_e` (IDLE, LAUNCH, WAIT, BCAST, DRAIN);
  - constants `XLEN_MIN` (`64'h8000…0`) and `W_MIN` (`64'hFFFF_FFFF_8000_0000`).
- Sub-module `div_operand_cond` is combinational. It covers operand extension for the W forms, the zero/overflow detection, and the bypass result. It is reused by the future REM controller.

## Test plan
1. DIVU 50/5, tag 3:
   - Exactly one divider handshake.
   - `cdb_req_o` with tag 3 and data 10.
   - `issue_ready_o` high the cycle after grant.
2. DIV `0x8000_0000_0000_0000` / all ones:
   - `div_valid_o` never asserted.
   - `cdb_data_o` = `0x8000_0000_0000_0000` with `cdb_req_o` at N+1.
3. DIVU 7/0 and DIVW 7/0:
   - No divider request.
   - `cdb_data_o` = `0xFFFF_FFFF_FFFF_FFFF`.
4. DIVW with rs1 = `0xDEAD_BEEF_FFFF_FFCE` (-50) and rs2 = `0x1234_5678_0000_0005`:
   - `div_dividend_o` = `0xFFFF_FFFF_FFFF_FFCE`.
   - Result `0xFFFF_FFFF_FFFF_FFF6` (-10).
5. Flush two cycles after LAUNCH completes:
   - DRAIN is entered.
   - `div_yumi_o` is pulsed on `div_valid_i`.
   - No `cdb_req_o`; IDLE follows the next cycle.
6. `cdb_grant_i` withheld for 5 cycles, then pulsed:
   - `cdb_req_o`, tag and data held constant.
   - `issue_ready_o` low throughout.
   - Single delivery.
